// File: rtl/power_pkg.sv
// Shared types and default sizing for the power-domain sequencer.
package power_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    UP   = 2'd1,
    ON   = 2'd2,
    DOWN = 2'd3
  } pwr_seq_state_t;

  localparam int PWR_NUM_DOMAINS_DEF = 4;
  localparam int PWR_CNT_W_DEF       = 8;

endpackage

// File: rtl/power_step_timer.sv
// Dwell down-counter: load wins over decrement, zero flag is decoded directly from the count.
module power_step_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/power_seq_ctrl.sv
// Reversible power-domain sequencer: thermometer-coded enables raised LSB-first on
// request, lowered MSB-first on release, with a programmable dwell between steps.
module power_seq_ctrl
  import power_pkg::*;
#(
  parameter int NUM_DOMAINS = PWR_NUM_DOMAINS_DEF,
  parameter int CNT_W       = PWR_CNT_W_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   pwr_req,
  input  logic [CNT_W-1:0]       step_delay,
  output logic [NUM_DOMAINS-1:0] dom_en,
  output logic                   pwr_good,
  output logic                   pwr_off,
  output logic                   busy
);

  pwr_seq_state_t state_q, state_d;
  logic [NUM_DOMAINS-1:0] dom_en_q, dom_en_d;
  logic pwr_good_q, pwr_off_q, busy_q;
  logic load, dec, zero;

  power_step_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load_i     (load),
    .dec_i      (dec),
    .load_val_i (step_delay),
    .zero_o     (zero)
  );

  always_comb begin
    state_d  = state_q;
    dom_en_d = dom_en_q;
    load     = 1'b0;
    dec      = 1'b0;
    unique case (state_q)
      OFF: begin
        if (pwr_req) begin
          state_d = UP;
          load    = 1'b1;
        end
      end
      UP: begin
        // A dropped request pre-empts any step that is due on this edge.
        if (!pwr_req) begin
          if (dom_en_q == '0) begin
            state_d = OFF;
          end else begin
            state_d = DOWN;
            load    = 1'b1;
          end
        end else if (!zero) begin
          dec = 1'b1;
        end else begin
          dom_en_d = {dom_en_q[NUM_DOMAINS-2:0], 1'b1};
          if (dom_en_d[NUM_DOMAINS-1]) begin
            state_d = ON;
          end else begin
            load = 1'b1;
          end
        end
      end
      ON: begin
        if (!pwr_req) begin
          state_d = DOWN;
          load    = 1'b1;
        end
      end
      DOWN: begin
        if (pwr_req) begin
          state_d = UP;
          load    = 1'b1;
        end else if (!zero) begin
          dec = 1'b1;
        end else begin
          dom_en_d = {1'b0, dom_en_q[NUM_DOMAINS-1:1]};
          if (dom_en_d == '0) begin
            state_d = OFF;
          end else begin
            load = 1'b1;
          end
        end
      end
      default: state_d = OFF;
    endcase
  end

  // Status flags are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= OFF;
      dom_en_q   <= '0;
      pwr_good_q <= 1'b0;
      pwr_off_q  <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dom_en_q   <= dom_en_d;
      pwr_good_q <= (state_d == ON);
      pwr_off_q  <= (state_d == OFF);
      busy_q     <= (state_d == UP) || (state_d == DOWN);
    end
  end

  assign dom_en   = dom_en_q;
  assign pwr_good = pwr_good_q;
  assign pwr_off  = pwr_off_q;
  assign busy     = busy_q;

endmodule
